// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter definitions: FSM encoding, default bus widths
// and a constant-friendly clog2 for sizing counters and indices.
package wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

   localparam int WB_NUM_MASTERS = 4;
   localparam int WB_ADDR_W      = 24;
   localparam int WB_DATA_W      = 16;
   localparam int WB_SEL_W       = WB_DATA_W / 8;

   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >>> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/wishbone_rr_arbiter_if.sv
// Bundle of every master-side and slave-side Wishbone signal around the
// arbiter. "master" is the environment's view, "slave" is the arbiter's view.
interface wishbone_rr_arbiter_if
   import wb_pkg::*;
#(
   parameter int NUM_MASTERS = WB_NUM_MASTERS,
   parameter int ADDR_W      = WB_ADDR_W,
   parameter int DATA_W      = WB_DATA_W,
   parameter int SEL_W       = WB_SEL_W
);

   logic [NUM_MASTERS-1:0]        i_m_cyc;
   logic [NUM_MASTERS-1:0]        i_m_stb;
   logic [NUM_MASTERS-1:0]        i_m_we;
   logic [NUM_MASTERS*ADDR_W-1:0] i_m_adr;
   logic [NUM_MASTERS*DATA_W-1:0] i_m_dat;
   logic [NUM_MASTERS*SEL_W-1:0]  i_m_sel;
   logic [NUM_MASTERS-1:0]        o_m_ack;
   logic [NUM_MASTERS-1:0]        o_m_err;
   logic [DATA_W-1:0]             o_m_dat;
   logic                          o_s_cyc;
   logic                          o_s_stb;
   logic                          o_s_we;
   logic [ADDR_W-1:0]             o_s_adr;
   logic [DATA_W-1:0]             o_s_dat;
   logic [SEL_W-1:0]              o_s_sel;
   logic                          i_s_ack;
   logic                          i_s_err;
   logic [DATA_W-1:0]             i_s_dat;
   logic [NUM_MASTERS-1:0]        o_grant;
   logic                          o_timeout;

   modport master (
      output i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_m_sel,
      output i_s_ack, i_s_err, i_s_dat,
      input  o_m_ack, o_m_err, o_m_dat,
      input  o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat, o_s_sel,
      input  o_grant, o_timeout
   );

   modport slave (
      input  i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_m_sel,
      input  i_s_ack, i_s_err, i_s_dat,
      output o_m_ack, o_m_err, o_m_dat,
      output o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat, o_s_sel,
      output o_grant, o_timeout
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. Reusable by any arbiter needing a rotating priority.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   // scan upward from the pointer and latch the first hit
   always_comb begin
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         int k;
         k = (int'(ptr) + i) % N;
         if (!vld && req[k]) begin
            vld    = 1'b1;
            gnt[k] = 1'b1;
            idx    = IDX_W'(k);
         end else begin
            vld = vld;
         end
      end
   end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// N-master round-robin Wishbone arbiter holding grant for a whole CYC
// tenancy, with a stall watchdog that breaks hung slaves with a bus error.
module wishbone_rr_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_MASTERS = WB_NUM_MASTERS,
   parameter int ADDR_W      = WB_ADDR_W,
   parameter int DATA_W      = WB_DATA_W,
   parameter int SEL_W       = WB_SEL_W,
   parameter int TIMEOUT     = 255
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   wishbone_rr_arbiter_if.slave  bus
);

   localparam int IDX_W = (clog2(NUM_MASTERS) < 1) ? 1 : clog2(NUM_MASTERS);
   localparam int WD_W  = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
   localparam bit WD_EN = (TIMEOUT != 0);
   localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0]  WD_MAX     = {WD_W{1'b1}};
   localparam logic [IDX_W-1:0] OWNER_LAST = IDX_W'(NUM_MASTERS - 1);

   arb_state_e             state_r, state_nxt_s;
   logic [NUM_MASTERS-1:0] grant_r, grant_nxt_s;
   logic [IDX_W-1:0]       owner_r, owner_nxt_s;
   logic [IDX_W-1:0]       ptr_r, ptr_nxt_s;
   logic [WD_W-1:0]        wdog_r, wdog_nxt_s;

   logic [NUM_MASTERS-1:0] pick_gnt_s;
   logic [IDX_W-1:0]       pick_idx_s;
   logic                   pick_vld_s;
   logic                   own_cyc_s;
   logic                   own_stb_s;
   logic                   stall_s;
   logic                   fire_s;

   rr_pick #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_pick (
      .req (bus.i_m_cyc),
      .ptr (ptr_r),
      .gnt (pick_gnt_s),
      .idx (pick_idx_s),
      .vld (pick_vld_s)
   );

   // owner handshake view and watchdog trip condition
   always_comb begin
      own_cyc_s = bus.i_m_cyc[owner_r];
      own_stb_s = bus.i_m_stb[owner_r];
      stall_s   = (state_r == ST_OWN) & own_stb_s & ~bus.i_s_ack & ~bus.i_s_err;
      // a same-cycle ack/err removes the stall, so ack beats the watchdog
      fire_s    = WD_EN & stall_s & (wdog_r == WD_LAST);
   end

   // next-state, grant, pointer and watchdog update
   always_comb begin
      state_nxt_s = state_r;
      grant_nxt_s = grant_r;
      owner_nxt_s = owner_r;
      ptr_nxt_s   = ptr_r;
      wdog_nxt_s  = '0;
      case (state_r)
         ST_IDLE: begin
            if (pick_vld_s) begin
               state_nxt_s = ST_OWN;
               grant_nxt_s = pick_gnt_s;
               owner_nxt_s = pick_idx_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_OWN: begin
            if (!own_cyc_s) begin
               state_nxt_s = ST_IDLE;
               grant_nxt_s = '0;
               ptr_nxt_s   = (owner_r == OWNER_LAST) ? '0 : owner_r + IDX_W'(1);
            end else if (fire_s) begin
               state_nxt_s = ST_DRAIN;
            end else if (stall_s) begin
               wdog_nxt_s = (wdog_r == WD_MAX) ? wdog_r : wdog_r + WD_W'(1);
            end else begin
               wdog_nxt_s = '0;
            end
         end
         ST_DRAIN: begin
            if (!own_cyc_s) begin
               state_nxt_s = ST_IDLE;
               grant_nxt_s = '0;
               ptr_nxt_s   = (owner_r == OWNER_LAST) ? '0 : owner_r + IDX_W'(1);
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            grant_nxt_s = '0;
         end
      endcase
   end

   // arbiter state registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         grant_r <= '0;
         owner_r <= '0;
         ptr_r   <= '0;
         wdog_r  <= '0;
      end else begin
         state_r <= state_nxt_s;
         grant_r <= grant_nxt_s;
         owner_r <= owner_nxt_s;
         ptr_r   <= ptr_nxt_s;
         wdog_r  <= wdog_nxt_s;
      end
   end

   // bus mux: slave sees the owner only while OWN, responses go to owner only
   always_comb begin
      bus.o_s_cyc   = 1'b0;
      bus.o_s_stb   = 1'b0;
      bus.o_s_we    = 1'b0;
      bus.o_s_adr   = '0;
      bus.o_s_dat   = '0;
      bus.o_s_sel   = '0;
      bus.o_m_ack   = '0;
      bus.o_m_err   = '0;
      bus.o_m_dat   = bus.i_s_dat;
      bus.o_grant   = grant_r;
      bus.o_timeout = fire_s;
      if (state_r == ST_OWN) begin
         bus.o_s_cyc          = own_cyc_s;
         bus.o_s_stb          = own_stb_s;
         bus.o_s_we           = bus.i_m_we[owner_r];
         bus.o_s_adr          = bus.i_m_adr[int'(owner_r)*ADDR_W +: ADDR_W];
         bus.o_s_dat          = bus.i_m_dat[int'(owner_r)*DATA_W +: DATA_W];
         bus.o_s_sel          = bus.i_m_sel[int'(owner_r)*SEL_W +: SEL_W];
         bus.o_m_ack[owner_r] = bus.i_s_ack & own_stb_s;
         bus.o_m_err[owner_r] = (bus.i_s_err & own_stb_s) | fire_s;
      end else begin
         bus.o_s_cyc = 1'b0;
      end
   end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed plus randomized bench for wishbone_rr_arbiter, checked every
// cycle against a tenancy-level reference model.
module tb_wishbone_rr_arbiter;

   localparam int N   = 4;
   localparam int AW  = 24;
   localparam int DW  = 16;
   localparam int SW  = 2;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   wishbone_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

   wishbone_rr_arbiter #(
      .NUM_MASTERS (N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .SEL_W       (SW),
      .TIMEOUT     (TMO)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: owner (-1 = idle), drain flag, rr pointer, stall count
   int m_owner;
   int m_ptr;
   int m_stall;
   bit m_drain;
   int hold [N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_stall = 0;
      m_drain = 1'b0;
   endtask

   function automatic bit model_fire();
      if (m_owner < 0 || m_drain) return 1'b0;
      return bus.i_m_stb[m_owner] && !bus.i_s_ack && !bus.i_s_err && (m_stall + 1 == TMO);
   endfunction

   task automatic check_model();
      logic [N-1:0]  eg, eack, eerr;
      logic          ecyc, estb, ewe;
      logic [AW-1:0] eadr;
      logic [DW-1:0] edat;
      logic [SW-1:0] esel;
      bit            fire;
      eg = '0; eack = '0; eerr = '0;
      ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
      eadr = '0; edat = '0; esel = '0;
      fire = model_fire();
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         if (!m_drain) begin
            ecyc = bus.i_m_cyc[m_owner];
            estb = bus.i_m_stb[m_owner];
            ewe  = bus.i_m_we[m_owner];
            eadr = bus.i_m_adr[m_owner*AW +: AW];
            edat = bus.i_m_dat[m_owner*DW +: DW];
            esel = bus.i_m_sel[m_owner*SW +: SW];
            eack[m_owner] = bus.i_s_ack & bus.i_m_stb[m_owner];
            eerr[m_owner] = (bus.i_s_err & bus.i_m_stb[m_owner]) | fire;
         end
      end
      chk("grant",   64'(bus.o_grant),   64'(eg));
      chk("s_cyc",   64'(bus.o_s_cyc),   64'(ecyc));
      chk("s_stb",   64'(bus.o_s_stb),   64'(estb));
      chk("s_we",    64'(bus.o_s_we),    64'(ewe));
      chk("s_adr",   64'(bus.o_s_adr),   64'(eadr));
      chk("s_dat",   64'(bus.o_s_dat),   64'(edat));
      chk("s_sel",   64'(bus.o_s_sel),   64'(esel));
      chk("m_ack",   64'(bus.o_m_ack),   64'(eack));
      chk("m_err",   64'(bus.o_m_err),   64'(eerr));
      chk("timeout", 64'(bus.o_timeout), 64'(fire));
      chk("m_dat",   64'(bus.o_m_dat),   64'(bus.i_s_dat));
   endtask

   task automatic model_update();
      bit fire;
      bit found;
      fire = model_fire();
      if (m_owner < 0) begin
         found = 1'b0;
         for (int i = 0; i < N; i++) begin
            int m;
            m = (m_ptr + i) % N;
            if (!found && bus.i_m_cyc[m]) begin
               found   = 1'b1;
               m_owner = m;
               m_stall = 0;
               m_drain = 1'b0;
            end
         end
      end else if (!bus.i_m_cyc[m_owner]) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
         m_stall = 0;
         m_drain = 1'b0;
      end else if (m_drain) begin
         m_stall = 0;
      end else if (fire) begin
         m_drain = 1'b1;
      end else if (bus.i_m_stb[m_owner] && !bus.i_s_ack && !bus.i_s_err) begin
         m_stall++;
      end else begin
         m_stall = 0;
      end
   endtask

   // one clock: settle, compare against model, advance DUT and model
   task automatic tick();
      #1;
      check_model();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_m_cyc = '0; bus.i_m_stb = '0; bus.i_m_we = '0;
      bus.i_m_adr = '0; bus.i_m_dat = '0; bus.i_m_sel = '0;
      bus.i_s_ack = 1'b0; bus.i_s_err = 1'b0; bus.i_s_dat = '0;
   endtask

   task automatic set_master(input int m, input bit cyc, input bit stb, input bit we,
                             input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                             input logic [SW-1:0] sel);
      bus.i_m_cyc[m] = cyc;
      bus.i_m_stb[m] = stb;
      bus.i_m_we[m]  = we;
      bus.i_m_adr[m*AW +: AW] = adr;
      bus.i_m_dat[m*DW +: DW] = dat;
      bus.i_m_sel[m*SW +: SW] = sel;
   endtask

   task automatic slave(input bit ack, input bit err);
      bus.i_s_ack = ack;
      bus.i_s_err = err;
      bus.i_s_dat = DW'($urandom);
   endtask

   task automatic rand_drive(input int ack_pct);
      bit c;
      for (int m = 0; m < N; m++) begin
         if (hold[m] > 0) begin
            hold[m]--;
            c = 1'b1;
         end else if (bus.i_m_cyc[m]) begin
            c = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            hold[m] = int'($urandom_range(1, 20));
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         set_master(m, c, c & ($urandom_range(0, 3) != 0), 1'($urandom),
                    AW'($urandom), DW'($urandom), SW'($urandom));
      end
      bus.i_s_ack = ($urandom_range(0, 99) < ack_pct);
      bus.i_s_err = !bus.i_s_ack && ($urandom_range(0, 99) < 3);
      bus.i_s_dat = DW'($urandom);
   endtask

   int order [4] = '{0, 1, 3, 0};

   initial begin
      // reset state
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      for (int m = 0; m < N; m++) hold[m] = 0;
      #2;
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      model_update();
      #1;

      // single master 2, slave acks two cycles after grant, release -> ptr 3
      set_master(2, 1'b1, 1'b1, 1'b1, 24'h2A0002, 16'hBEEF, 2'b11);
      slave(1'b0, 1'b0);
      tick();
      #1;
      chk("t1_grant", 64'(bus.o_grant), 64'(4'b0100));
      chk("t1_adr",   64'(bus.o_s_adr), 64'(24'h2A0002));
      tick();
      tick();
      slave(1'b1, 1'b0);
      #1;
      chk("t1_ack", 64'(bus.o_m_ack), 64'(4'b0100));
      tick();
      set_master(2, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
      slave(1'b0, 1'b0);
      tick();
      #1;
      chk("t1_rel", 64'(bus.o_grant), 64'(4'b0000));
      set_master(0, 1'b1, 1'b1, 1'b0, 24'h000100, 16'h0001, 2'b01);
      set_master(3, 1'b1, 1'b1, 1'b0, 24'h000300, 16'h0003, 2'b10);
      tick();
      #1;
      chk("t1_ptr3", 64'(bus.o_grant), 64'(4'b1000));
      set_master(0, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
      set_master(3, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
      tick();
      tick();

      // masters 0,1,3 with ptr 0: order 0,1,3 then 0 again, idle gap each time
      slave(1'b1, 1'b0);
      set_master(0, 1'b1, 1'b1, 1'b0, 24'h000010, 16'h1000, 2'b11);
      set_master(1, 1'b1, 1'b1, 1'b1, 24'h000011, 16'h1001, 2'b11);
      set_master(3, 1'b1, 1'b1, 1'b1, 24'h000013, 16'h1003, 2'b11);
      for (int j = 0; j < 4; j++) begin
         tick();
         #1;
         chk("t2_grant", 64'(bus.o_grant), 64'(4'b0001 << order[j]));
         tick();
         set_master(order[j], 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
         tick();
         if (j == 0) begin
            set_master(0, 1'b1, 1'b1, 1'b0, 24'h000020, 16'h2000, 2'b01);
         end
         #1;
         chk("t2_idle", 64'(bus.o_grant), 64'(4'b0000));
      end

      // owner 2 holds CYC over 3 beats while master 1 waits
      set_master(2, 1'b1, 1'b1, 1'b0, 24'h002000, 16'h0, 2'b11);
      slave(1'b0, 1'b0);
      tick();
      #1;
      chk("t3_grant", 64'(bus.o_grant), 64'(4'b0100));
      set_master(1, 1'b1, 1'b1, 1'b1, 24'h001000, 16'h1111, 2'b11);
      for (int b = 0; b < 3; b++) begin
         set_master(2, 1'b1, 1'b1, 1'b0, AW'(24'h002000 + b), DW'($urandom), 2'b11);
         slave(1'b1, 1'b0);
         #1;
         chk("t3_beat", 64'(bus.o_m_ack), 64'(4'b0100));
         tick();
      end
      #1;
      chk("t3_hold", 64'(bus.o_grant), 64'(4'b0100));
      set_master(2, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
      slave(1'b0, 1'b0);
      tick();
      #1;
      chk("t3_gap", 64'(bus.o_grant), 64'(4'b0000));
      tick();
      #1;
      chk("t3_next", 64'(bus.o_grant), 64'(4'b0010));
      set_master(1, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
      tick();
      tick();

      // watchdog: slave never acks, error and timeout on stall cycle 8
      set_master(0, 1'b1, 1'b1, 1'b0, 24'h00DEAD, 16'h0, 2'b11);
      slave(1'b0, 1'b0);
      tick();
      for (int k = 1; k <= 8; k++) begin
         #1;
         chk("t4_tmo", 64'(bus.o_timeout), 64'(k == 8));
         chk("t4_err", 64'(bus.o_m_err),   64'((k == 8) ? 4'b0001 : 4'b0000));
         tick();
      end
      #1;
      chk("t4_drain_cyc",   64'(bus.o_s_cyc), 64'(1'b0));
      chk("t4_drain_grant", 64'(bus.o_grant), 64'(4'b0001));
      slave(1'b1, 1'b0);
      #1;
      chk("t4_late_ack", 64'(bus.o_m_ack), 64'(4'b0000));
      tick();
      tick();
      slave(1'b0, 1'b0);
      set_master(0, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
      tick();
      #1;
      chk("t4_rel", 64'(bus.o_grant), 64'(4'b0000));

      // ack exactly on the 8th stall cycle wins over the watchdog
      set_master(1, 1'b1, 1'b1, 1'b0, 24'h00BEEF, 16'h0, 2'b11);
      tick();
      for (int k = 1; k <= 7; k++) tick();
      slave(1'b1, 1'b0);
      #1;
      chk("t5_ack", 64'(bus.o_m_ack),   64'(4'b0010));
      chk("t5_err", 64'(bus.o_m_err),   64'(4'b0000));
      chk("t5_tmo", 64'(bus.o_timeout), 64'(1'b0));
      tick();
      slave(1'b0, 1'b0);
      #1;
      chk("t5_still_own", 64'(bus.o_s_cyc), 64'(1'b1));
      set_master(1, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
      tick();
      tick();

      // asynchronous reset mid-tenancy, then pointer restarts at 0
      set_master(2, 1'b1, 1'b1, 1'b1, 24'h00CAFE, 16'h5555, 2'b01);
      tick();
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_cyc",   64'(bus.o_s_cyc), 64'(1'b0));
      chk("t6_rst_grant", 64'(bus.o_grant), 64'(4'b0000));
      model_reset();
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      model_update();
      #1;
      set_master(1, 1'b1, 1'b1, 1'b0, 24'h000001, 16'h0, 2'b11);
      set_master(3, 1'b1, 1'b1, 1'b0, 24'h000003, 16'h0, 2'b11);
      tick();
      #1;
      chk("t6_ptr0", 64'(bus.o_grant), 64'(4'b0010));
      clear_inputs();
      tick();
      tick();

      // randomized traffic: responsive slave, then a sluggish one
      for (int i = 0; i < 400; i++) begin
         rand_drive(40);
         tick();
      end
      for (int i = 0; i < 400; i++) begin
         rand_drive(5);
         tick();
      end
      clear_inputs();
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
